// File: rtl/usb_tx_pkt_pkg.sv
// rtl/usb_tx_pkt_pkg.sv - shared USB PID/CRC16 definitions and TX state type
package usb_tx_pkt_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } tx_state_t;

    // One bit of the reflected CRC16: shift right, fold in poly when feedback is set
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

    // DATA0/DATA1/DATA2/MDATA all share 2'b11 in the low PID bits
    function automatic logic pid_is_data(input logic [3:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

    // Wire form of the PID: check nibble in the upper half
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_pkt_if.sv
// rtl/usb_tx_pkt_if.sv - TX packet and PHY bit handshake bundle
interface usb_tx_pkt_if;
    logic       pkt_start;
    logic       pkt_done;
    logic [3:0] pkt_pid;
    logic [9:0] pkt_len;
    logic [7:0] pkt_data;
    logic       pkt_data_ack;
    logic       ll_start;
    logic       ll_bit;
    logic       ll_last;
    logic       ll_ack;

    modport master (
        output pkt_start, pkt_pid, pkt_len, pkt_data, ll_ack,
        input  pkt_done, pkt_data_ack, ll_start, ll_bit, ll_last
    );

    modport slave (
        input  pkt_start, pkt_pid, pkt_len, pkt_data, ll_ack,
        output pkt_done, pkt_data_ack, ll_start, ll_bit, ll_last
    );
endinterface

// File: rtl/usb_crc16_serial.sv
// rtl/usb_crc16_serial.sv - bit-serial reflected CRC16 with init and enable
module usb_crc16_serial
    import usb_tx_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    // Init wins over enable so a new packet can restart the CRC on any cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC16_INIT;
        end else if (init) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/usb_tx_pkt.sv
// rtl/usb_tx_pkt.sv - USB packet serializer: PID, payload and CRC16, LSB first
module usb_tx_pkt
    import usb_tx_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    usb_tx_pkt_if.slave bus
);

    tx_state_t   state;
    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic [9:0]  rem;
    logic        is_data;
    logic        ll_start_r;
    logic        ll_last_r;
    logic        pkt_done_r;

    logic [15:0] crc;
    logic [15:0] crc_final;
    logic        start_ok;
    logic        ack_ok;
    logic        byte_end;
    logic        load_byte;
    logic        crc_en;

    assign start_ok  = bus.pkt_start && (state == ST_IDLE);
    assign ack_ok    = bus.ll_ack && (state == ST_PID || state == ST_DATA || state == ST_CRC);
    assign byte_end  = ack_ok && (state != ST_CRC) && (bit_cnt == 4'd7);
    // rem is forced to zero for PID-only packets, so no payload is ever fetched for them
    assign load_byte = byte_end && (rem != 10'd0);
    assign crc_en    = ack_ok && (state == ST_DATA);

    // The CRC bits must be loaded on the same ack that shifts out the last payload
    // bit, so fold that bit in here rather than waiting for the register
    assign crc_final = crc_en ? crc16_step(crc, shreg[0]) : crc;

    usb_crc16_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (start_ok),
        .en    (crc_en),
        .din   (shreg[0]),
        .crc   (crc)
    );

    assign bus.ll_bit       = shreg[0];
    assign bus.ll_start     = ll_start_r;
    assign bus.ll_last      = ll_last_r;
    assign bus.pkt_done     = pkt_done_r;
    assign bus.pkt_data_ack = load_byte;

    // Packet sequencer: one shift register feeds every bit; bytes and CRC are loaded on the completing ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            rem        <= '0;
            is_data    <= 1'b0;
            ll_start_r <= 1'b0;
            ll_last_r  <= 1'b0;
            pkt_done_r <= 1'b0;
        end else begin
            ll_start_r <= 1'b0;
            pkt_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.pkt_start) begin
                        state      <= ST_PID;
                        shreg      <= {8'h00, pid_byte(bus.pkt_pid)};
                        bit_cnt    <= '0;
                        is_data    <= pid_is_data(bus.pkt_pid);
                        rem        <= pid_is_data(bus.pkt_pid) ? bus.pkt_len : 10'd0;
                        ll_start_r <= 1'b1;
                        ll_last_r  <= 1'b0;
                    end
                end
                ST_PID, ST_DATA: begin
                    if (bus.ll_ack) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        shreg   <= shreg >> 1;
                        if (state == ST_PID && !is_data && bit_cnt == 4'd6) begin
                            ll_last_r <= 1'b1;
                        end
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (!is_data) begin
                                state      <= ST_DONE;
                                ll_last_r  <= 1'b0;
                                pkt_done_r <= 1'b1;
                            end else if (rem != 10'd0) begin
                                state <= ST_DATA;
                                shreg <= {8'h00, bus.pkt_data};
                                rem   <= rem - 10'd1;
                            end else begin
                                state <= ST_CRC;
                                shreg <= ~crc_final;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (bus.ll_ack) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        shreg   <= shreg >> 1;
                        if (bit_cnt == 4'd14) begin
                            ll_last_r <= 1'b1;
                        end
                        if (bit_cnt == 4'd15) begin
                            bit_cnt    <= '0;
                            state      <= ST_DONE;
                            ll_last_r  <= 1'b0;
                            pkt_done_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
